// File: rtl/strum_score_scheduler_pkg.sv
// strum_score_scheduler_pkg: shared encodings for the score-event scheduler.
package strum_score_scheduler_pkg;
    localparam logic [31:0] INJ_INC = 32'h28400002;
    localparam logic [31:0] INJ_DEC = 32'h28400000;
    localparam logic EV_INC = 1'b1;
    localparam logic EV_DEC = 1'b0;
    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
endpackage

// File: rtl/strum_score_scheduler_if.sv
// strum_score_scheduler_if: injection handshake between scheduler and fetch.
interface strum_score_scheduler_if;
    logic        inj_valid;
    logic [31:0] inj_instr;
    logic        inj_ack;
    logic        pc_hold;
    modport master (output inj_valid, inj_instr, pc_hold, input inj_ack);
    modport slave  (input inj_valid, inj_instr, pc_hold, output inj_ack);
endinterface

// File: rtl/strum_score_scheduler_event_fifo.sv
// sched_event_fifo: DEPTH x 1-bit circular event queue with wrap-around pointers.
module sched_event_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic push_i,
    input  logic data_i,
    input  logic pop_i,
    output logic head_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             pop_ok, push_ok;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign head_o  = mem_q[rd_q];
    assign pop_ok  = pop_i & ~empty_o;
    // a full queue still accepts a push when the head leaves in the same cycle
    assign push_ok = push_i & (~full_o | pop_ok);
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) mem_q[wr_q] <= data_i;
            wr_q  <= wr_q + AW'(push_ok);
            rd_q  <= rd_q + AW'(pop_ok);
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
endmodule

// File: rtl/strum_score_scheduler.sv
// strum_score_scheduler: judges debounced strums, queues score events and
// injects them one at a time into fetch while holding the PC.
module strum_score_scheduler
    import strum_score_scheduler_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int GAP_CYCLES      = 2,
    parameter int BONUS_EVERY     = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            strum_i,
    input  logic [3:0]                      buttons_i,
    input  logic [3:0]                      intersections_i,
    strum_score_scheduler_if.master         inj,
    output logic [7:0]                      combo_o,
    output logic [31:0]                     score_shadow_o,
    output logic [7:0]                      drop_count_o
);
    state_t      state_q, state_d;
    logic [2:0]  sync_q;
    logic [7:0]  deb_q, gap_q, gap_d, combo_q, combo_d, drop_q;
    logic [31:0] score_q, score_d;
    logic        ev_valid_q, ev_hit_q, bonus_q, bonus_d;
    logic        edge_w, hit_w, push_w, pop_w, head_w, full_w, empty_w;
    assign edge_w = sync_q[1] & ~sync_q[2] & (deb_q == '0);
    assign hit_w  = (intersections_i != '0) && (buttons_i == intersections_i);
    assign push_w = ev_valid_q | bonus_q;
    assign combo_d = !ev_valid_q ? combo_q : !ev_hit_q ? 8'd0 :
                     (combo_q == 8'hff) ? combo_q : combo_q + 8'd1;
    assign bonus_d = ev_valid_q & ev_hit_q & (combo_d != '0) &
                     ((combo_d % 8'(BONUS_EVERY)) == '0);
    sched_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .push_i (push_w),
        .data_i (ev_valid_q ? (ev_hit_q ? EV_INC : EV_DEC) : EV_INC),
        .pop_i  (pop_w),
        .head_o (head_w),
        .full_o (full_w),
        .empty_o(empty_w)
    );
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        score_d = score_q;
        pop_w   = 1'b0;
        unique case (state_q)
            IDLE:  if (!empty_w) state_d = ISSUE;
            ISSUE: if (inj.inj_ack) begin
                pop_w   = 1'b1;
                score_d = (head_w == EV_INC) ? score_q + 32'd1 :
                          (score_q == '0) ? '0 : score_q - 32'd1;
                gap_d   = 8'(GAP_CYCLES - 1);
                state_d = GAP;
            end
            GAP: begin
                state_d = (gap_q == '0) ? IDLE : GAP;
                gap_d   = (gap_q == '0) ? gap_q : gap_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            deb_q      <= '0;
            gap_q      <= '0;
            combo_q    <= '0;
            drop_q     <= '0;
            score_q    <= '0;
            ev_valid_q <= 1'b0;
            ev_hit_q   <= 1'b0;
            bonus_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[1:0], strum_i};
            deb_q      <= edge_w ? 8'(DEBOUNCE_CYCLES) : (deb_q != '0) ? deb_q - 8'd1 : deb_q;
            gap_q      <= gap_d;
            combo_q    <= combo_d;
            drop_q     <= drop_q + 8'(push_w && full_w && !pop_w && drop_q != 8'hff);
            score_q    <= score_d;
            ev_valid_q <= edge_w;
            ev_hit_q   <= hit_w;
            bonus_q    <= bonus_d;
        end
    assign inj.inj_valid = state_q == ISSUE;
    assign inj.inj_instr = (state_q != ISSUE) ? '0 : (head_w == EV_INC) ? INJ_INC : INJ_DEC;
    assign inj.pc_hold   = state_q != IDLE;
    assign combo_o        = combo_q;
    assign score_shadow_o = score_q;
    assign drop_count_o   = drop_q;
endmodule

// File: tb/tb_strum_score_scheduler.sv
// tb_strum_score_scheduler: directed strums with a scoreboard of expected injections.
module tb_strum_score_scheduler;
    localparam logic [31:0] INC = 32'h28400002;
    localparam logic [31:0] DEC = 32'h28400000;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        strum = 1'b0;
    logic [3:0]  buttons = '0, intersections = '0;
    logic [7:0]  combo, drop_count;
    logic [31:0] score_shadow;
    logic        ack_en = 1'b1;
    int          checks = 0, failures = 0;
    logic [31:0] exp_q[$];
    strum_score_scheduler_if inj_if();
    strum_score_scheduler dut (
        .clock          (clock),
        .reset          (reset),
        .strum_i        (strum),
        .buttons_i      (buttons),
        .intersections_i(intersections),
        .inj            (inj_if.master),
        .combo_o        (combo),
        .score_shadow_o (score_shadow),
        .drop_count_o   (drop_count)
    );
    always #5 clock = ~clock;
    initial inj_if.inj_ack = 1'b0;

    // monitor: compares each new presentation with the scoreboard and drives ack
    logic        prev_v = 1'b0;
    int          low_cnt = 100;
    logic [31:0] held, exp_v;
    always @(negedge clock) begin
        if (inj_if.inj_valid) begin
            if (!prev_v) begin
                checks++;
                if (low_cnt < 3) begin
                    failures++;
                    $display("FAIL gap: valid low %0d cycles, need >= 3", low_cnt);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected injection got %h, none expected", inj_if.inj_instr);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (inj_if.inj_instr !== exp_v) begin
                        failures++;
                        $display("FAIL instr got %h exp %h", inj_if.inj_instr, exp_v);
                    end
                end
                held = inj_if.inj_instr;
            end else begin
                checks++;
                if (inj_if.inj_instr !== held) begin
                    failures++;
                    $display("FAIL instr_stable got %h exp %h", inj_if.inj_instr, held);
                end
            end
            low_cnt = 0;
        end else low_cnt++;
        prev_v = inj_if.inj_valid;
        inj_if.inj_ack = inj_if.inj_valid && ack_en;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    task automatic strum_ev(input logic [3:0] b, input logic [3:0] i);
        @(negedge clock);
        buttons = b;
        intersections = i;
        strum = 1'b1;
        repeat (3) @(negedge clock);
        strum = 1'b0;
        repeat (6) @(negedge clock);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || inj_if.pc_hold) && t < 400) begin
            @(negedge clock);
            t++;
        end
        chk("drain_done", 32'(t < 400), 32'd1);
        repeat (4) @(negedge clock);
    endtask

    initial begin
        int n, hc;
        repeat (3) @(negedge clock);
        chk("rst_valid", 32'(inj_if.inj_valid), 0);
        chk("rst_pc_hold", 32'(inj_if.pc_hold), 0);
        chk("rst_instr", inj_if.inj_instr, 0);
        chk("rst_combo", 32'(combo), 0);
        chk("rst_score", score_shadow, 0);
        chk("rst_drop", 32'(drop_count), 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        // first hit: latency and hold length
        exp_q.push_back(INC);
        buttons = 4'b0010;
        intersections = 4'b0010;
        strum = 1'b1;
        n = 0;
        while (n < 20) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (inj_if.inj_valid) break;
        end
        chk("latency_edges", n, 5);
        strum = 1'b0;
        hc = 1;
        repeat (10) begin
            @(negedge clock);
            hc += int'(inj_if.pc_hold);
        end
        chk("pc_hold_cycles", hc, 3);
        chk("t1_score", score_shadow, 1);
        chk("t1_combo", 32'(combo), 1);
        // misses: score 1 -> 0, then saturates at 0
        exp_q.push_back(DEC);
        strum_ev(4'b0001, 4'b0010);
        exp_q.push_back(DEC);
        strum_ev(4'b0000, 4'b0000);
        drain();
        chk("t2_score", score_shadow, 0);
        chk("t2_combo", 32'(combo), 0);
        // eight hits: the eighth earns a bonus INC
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back(INC);
            if (k == 8) exp_q.push_back(INC);
            strum_ev(4'b0101, 4'b0101);
        end
        drain();
        chk("t3_score", score_shadow, 9);
        chk("t3_combo", 32'(combo), 8);
        // ack withheld: four queued, two dropped, then drained in order
        @(negedge clock);
        ack_en = 1'b0;
        exp_q.push_back(INC);
        exp_q.push_back(DEC);
        exp_q.push_back(INC);
        exp_q.push_back(DEC);
        strum_ev(4'b1000, 4'b1000);
        strum_ev(4'b1000, 4'b0100);
        strum_ev(4'b0011, 4'b0011);
        strum_ev(4'b0000, 4'b0001);
        strum_ev(4'b1111, 4'b1111);
        strum_ev(4'b0100, 4'b0100);
        chk("t4_drop", 32'(drop_count), 2);
        chk("t4_combo", 32'(combo), 2);
        chk("t4_still_valid", 32'(inj_if.inj_valid), 1);
        ack_en = 1'b1;
        drain();
        chk("t4_score", score_shadow, 9);
        // strum toggling inside the debounce window yields one event
        exp_q.push_back(INC);
        @(negedge clock);
        buttons = 4'b0110;
        intersections = 4'b0110;
        strum = 1'b1;
        @(negedge clock) strum = 1'b0;
        @(negedge clock) strum = 1'b1;
        @(negedge clock) strum = 1'b0;
        repeat (8) @(negedge clock);
        drain();
        chk("t5_score", score_shadow, 10);
        chk("t5_combo", 32'(combo), 3);
        // asynchronous reset mid-handshake
        ack_en = 1'b0;
        exp_q.push_back(INC);
        buttons = 4'b0001;
        intersections = 4'b0001;
        strum = 1'b1;
        n = 0;
        while (n < 20 && !inj_if.inj_valid) begin
            @(negedge clock);
            n++;
        end
        chk("t6_valid_seen", 32'(inj_if.inj_valid), 1);
        strum = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("t6_valid", 32'(inj_if.inj_valid), 0);
        chk("t6_pc_hold", 32'(inj_if.pc_hold), 0);
        chk("t6_combo", 32'(combo), 0);
        chk("t6_score", score_shadow, 0);
        chk("t6_drop", 32'(drop_count), 0);
        exp_q.delete();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        ack_en = 1'b1;
        repeat (25) @(negedge clock);
        chk("t6_no_issue", 32'(inj_if.pc_hold), 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
